dma_burst_engine: RTL

//  System-side DMA behind the JTAG chain-1 controller. On a start pulse it moves one

---
 rtl/dma_burst_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dma_burst_engine.sv
// System-side DMA engine: moves one burst between the DMA half of the ping-pong
// buffer and the system bus (write: buffer -> bus, read: bus -> buffer).
module dma_burst_engine #(
  parameter int BUF_AW = 8
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [31:0]       dma_address,
  input  logic [3:0]        dma_byte_enable,
  input  logic [7:0]        dma_burst_size,
  input  logic              dma_data_ready,
  input  logic              dma_readReady,
  output logic              switch_ready,
  output logic              dma_busy,
  output logic              dma_error,
  output logic [BUF_AW:0]   pp_address,
  output logic              pp_writeEnable,
  output logic [31:0]       pp_dataIn,
  input  logic [31:0]       pp_dataOut,
  output logic              bus_request_out,
  input  logic              bus_grant_in,
  output logic              bus_begin_transaction_out,
  output logic [31:0]       bus_address_data_out,
  output logic [3:0]        bus_byte_enables_out,
  output logic [7:0]        bus_burst_size_out,
  output logic              bus_read_n_write_out,
  output logic              bus_data_valid_out,
  output logic              bus_end_transaction_out,
  input  logic [31:0]       bus_address_data_in,
  input  logic              bus_data_valid_in,
  input  logic              bus_end_transaction_in,
  input  logic              bus_busy_in,
  input  logic              bus_error_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEGIN, S_W_FETCH, S_W_DATA, S_END, S_R_DATA
  } state_t;

  state_t              r_state;
  logic                r_error;
  logic                r_full;
  logic                r_rnw;
  logic [BUF_AW-1:0]   r_idx;
  logic [31:0]         r_addr;
  logic [3:0]          r_be;
  logic [7:0]          r_burst;

  state_t              w_state_nxt;
  logic                w_error_nxt;
  logic                w_full_nxt;
  logic [BUF_AW-1:0]   w_idx_nxt;
  logic                w_accept;
  logic                w_idx_last;
  logic                w_rd_take;

  assign w_idx_last = (r_idx == BUF_AW'(r_burst));
  // r_full marks that word 'burst' has been stored, so idx never has to wrap.
  assign w_rd_take  = bus_data_valid_in && !r_full;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_error <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_error <= w_error_nxt;
      r_full  <= w_full_nxt;
    end
  end

  always_ff @(posedge clock) begin
    r_idx <= w_idx_nxt;
    if (w_accept) begin
      r_addr  <= dma_address;
      r_be    <= dma_byte_enable;
      r_burst <= dma_burst_size;
      r_rnw   <= !dma_data_ready;
    end
  end

  always_comb begin
    w_state_nxt               = r_state;
    w_error_nxt               = r_error;
    w_full_nxt                = r_full;
    w_idx_nxt                 = r_idx;
    w_accept                  = 1'b0;
    switch_ready              = 1'b0;
    dma_busy                  = (r_state != S_IDLE);
    dma_error                 = r_error;
    pp_address                = '0;
    pp_writeEnable            = 1'b0;
    pp_dataIn                 = '0;
    bus_request_out           = 1'b0;
    bus_begin_transaction_out = 1'b0;
    bus_address_data_out      = '0;
    bus_byte_enables_out      = '0;
    bus_burst_size_out        = '0;
    bus_read_n_write_out      = 1'b0;
    bus_data_valid_out        = 1'b0;
    bus_end_transaction_out   = 1'b0;

    case (r_state)
      S_IDLE: begin
        switch_ready = 1'b1;
        if (dma_data_ready || dma_readReady) begin
          w_accept    = 1'b1;
          w_error_nxt = 1'b0;
          w_full_nxt  = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        bus_request_out = 1'b1;
        if (bus_grant_in) w_state_nxt = S_BEGIN;
      end
      S_BEGIN: begin
        bus_request_out           = 1'b1;
        bus_begin_transaction_out = 1'b1;
        bus_address_data_out      = r_addr;
        bus_byte_enables_out      = r_be;
        bus_burst_size_out        = r_burst;
        bus_read_n_write_out      = r_rnw;
        if (bus_error_in) begin
          w_error_nxt = 1'b1;
          w_state_nxt = r_rnw ? S_IDLE : S_END;
        end else begin
          w_state_nxt = r_rnw ? S_R_DATA : S_W_FETCH;
        end
      end
      S_W_FETCH: begin
        bus_request_out = 1'b1;
        pp_address      = {1'b0, r_idx};
        if (bus_error_in) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_END;
        end else begin
          w_state_nxt = S_W_DATA;
        end
      end
      S_W_DATA: begin
        bus_request_out      = 1'b1;
        pp_address           = {1'b0, r_idx};
        bus_data_valid_out   = 1'b1;
        bus_address_data_out = pp_dataOut;
        if (bus_error_in) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_END;
        end else if (!bus_busy_in) begin
          if (w_idx_last) begin
            w_state_nxt = S_END;
          end else begin
            w_idx_nxt   = r_idx + BUF_AW'(1);
            w_state_nxt = S_W_FETCH;
          end
        end
      end
      S_END: begin
        bus_request_out         = 1'b1;
        bus_end_transaction_out = 1'b1;
        w_state_nxt             = S_IDLE;
      end
      S_R_DATA: begin
        bus_request_out = 1'b1;
        if (w_rd_take) begin
          pp_writeEnable = 1'b1;
          pp_address     = {1'b0, r_idx};
          pp_dataIn      = bus_address_data_in;
          if (w_idx_last) w_full_nxt = 1'b1;
          else            w_idx_nxt  = r_idx + BUF_AW'(1);
        end
        if (bus_error_in) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus_end_transaction_in) begin
          // A word arriving together with the end strobe still counts toward the burst.
          if (!(r_full || (w_rd_take && w_idx_last))) w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
